rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-port controller for the 32x32 two-read/one-write register file (`Reg2R1W`) of the DIP RISC-V core. It shares the single write port between the ALU writeback requester and the load/store (LSU) writeback requester using round-robin arbitration, and drops writes to x0. It also sequences a hardware clear of x1..x31 after reset or on request. It sits between the execute/memory stages and the register file and drives the file's `wrReg`/`wrData`/`writeEnable` directly.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width (32 registers)
- `CLEAR_ON_RESET`, 1, 1 = enter CLEAR after reset; 0 = enter ARB directly

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU writeback request
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `lsu_valid`  in  1  LSU writeback request
- `lsu_rd`  in  ADDR_W  LSU destination register
- `lsu_data`  in  DATA_W  load result
- `lsu_ready`  out  1  LSU request accepted this cycle
- `init_req`  in  1  one-cycle pulse; re-clear x1..x31
- `busy`  out  1  high while in CLEAR
- `wrReg`  out  ADDR_W  register-file write index (registered)
- `wrData`  out  DATA_W  register-file write data (registered)
- `writeEnable`  out  1  register-file write strobe (registered)

## Operation
- States: CLEAR, ARB. Reset state is CLEAR if `CLEAR_ON_RESET`=1, otherwise ARB. Clear counter resets to 1.
- CLEAR: each cycle, issue a write of 0 to register `cnt` and increment `cnt`, for `cnt` = 1..31. After the write of 31 is issued, go to ARB and reset `cnt` to 1. Both readies are 0. `busy`=1. `init_req` is ignored.
- ARB, grant logic (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester not granted last.
  - `last_grant` resets to LSU, so the first tie goes to the ALU.
  - `last_grant` updates only on an accepted transfer.
- `x_ready` = state==ARB && !`init_req` && grant_x. A transfer occurs when valid && ready.
- Requesters hold valid, rd and data stable until ready; a valid request is never withdrawn.
- On a transfer, the next registered outputs are `wrReg`=rd and `wrData`=data. `writeEnable`=1 only if rd!=0. A transfer with rd==0 is accepted (ready=1), but `writeEnable` stays 0 and `wrReg`/`wrData` hold their previous values.
- No transfer in a cycle: `writeEnable` goes to 0 and `wrReg`/`wrData` hold.
- `init_req` in ARB: it takes precedence over any request in the same cycle (no grant). Next state is CLEAR.
- x0 is never written by this block, in either state.

## Timing
- Reset values: `writeEnable`=0, `wrReg`=0, `wrData`=0, `busy`=`CLEAR_ON_RESET`, `last_grant`=LSU. During reset, readies are 0 if `CLEAR_ON_RESET`=1; otherwise they follow the ARB rules.
- Latency: a transfer accepted at edge N produces `writeEnable`=1 during cycle N..N+1, and the register file captures it at edge N+1.
- Throughput: one accepted write per cycle. With both requesters continuously valid, grants strictly alternate ALU, LSU, ALU, ...
- CLEAR lasts exactly 31 cycles (writes to x1..x31). The first ARB grant is possible in the cycle after the write to x31 is issued.
- `init_req` sampled at edge N: the first clear write (x1) appears on the outputs after edge N+1. `busy` rises after edge N+1.
- `rst` asserted mid-CLEAR or mid-transfer: outputs go to reset values immediately, the pending write is lost, and clearing restarts from x1.

## Test plan
- Reset with `CLEAR_ON_RESET`=1 → 31 consecutive cycles of `writeEnable`=1, `wrReg`=1..31, `wrData`=0, then `busy`=0. Reading all registers through the file returns 0.
- ALU only: `alu_rd`=5, `alu_data`=0x50 → `alu_ready`=1 that cycle; next cycle `writeEnable`=1, `wrReg`=5, `wrData`=0x50. The file then reads REG[5]=80.
- Both valid for 4 cycles (ALU rd=3/data=0x30, LSU rd=7/data=0x70, each request replaced after acceptance) → grant order ALU, LSU, ALU, LSU. Writes to 3 and 7 alternate, and neither ready is starved.
- LSU `lsu_rd`=0, `lsu_data`=0xDEAD → `lsu_ready`=1, `writeEnable` stays 0; REG[0] reads 0.
- Write x4 with 0x40, then pulse `init_req` together with `alu_valid` → `alu_ready`=0 that cycle. CLEAR runs for 31 cycles, REG[4] reads 0, and the held ALU request is accepted on the first ARB cycle.
- Assert `rst` at clear cycle 10 for one cycle → outputs return to 0 at once. The clear restarts at `wrReg`=1 and completes all 31 writes.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the Reg2R1W register file: round-robin sharing of the
// single write port between ALU and LSU writeback, x0 filtering, and x1..x31 clearing.
module rf_wb_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,

    input  logic              init_req,
    output logic              busy,

    output logic [ADDR_W-1:0] wrReg,
    output logic [DATA_W-1:0] wrData,
    output logic              writeEnable
);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : ARB;
    localparam logic [ADDR_W-1:0] FIRST_IDX   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = '1;

    state_t            stateReg;
    state_t            stateNext;
    logic [ADDR_W-1:0] cntReg;
    logic [ADDR_W-1:0] cntNext;
    logic              lastGrantLsuReg;
    logic              lastGrantLsuNext;
    logic              busyReg;

    logic              weNext;
    logic [ADDR_W-1:0] wrRegNext;
    logic [DATA_W-1:0] wrDataNext;

    logic              grantAlu;
    logic              grantLsu;
    logic              arbOpen;
    logic              aluXfer;
    logic              lsuXfer;
    logic              anyXfer;
    logic [ADDR_W-1:0] selRd;
    logic [DATA_W-1:0] selData;

    // On a tie the requester that did not win the last accepted transfer goes first.
    always_comb begin
        grantAlu = alu_valid && (!lsu_valid || lastGrantLsuReg);
        grantLsu = lsu_valid && (!alu_valid || !lastGrantLsuReg);
    end

    // A clear request closes the port in the very cycle it is raised.
    assign arbOpen   = (stateReg == ARB) && !init_req;
    assign alu_ready = arbOpen && grantAlu;
    assign lsu_ready = arbOpen && grantLsu;

    assign aluXfer = alu_valid && alu_ready;
    assign lsuXfer = lsu_valid && lsu_ready;
    assign anyXfer = aluXfer || lsuXfer;

    always_comb begin
        selRd   = lsuXfer ? lsu_rd   : alu_rd;
        selData = lsuXfer ? lsu_data : alu_data;
    end

    always_comb begin
        stateNext        = stateReg;
        cntNext          = cntReg;
        lastGrantLsuNext = lastGrantLsuReg;
        weNext           = 1'b0;
        wrRegNext        = wrReg;
        wrDataNext       = wrData;

        case (stateReg)
            CLEAR: begin
                weNext     = 1'b1;
                wrRegNext  = cntReg;
                wrDataNext = '0;
                if (cntReg == LAST_IDX) begin
                    stateNext = ARB;
                    cntNext   = FIRST_IDX;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            ARB: begin
                if (init_req) begin
                    stateNext = CLEAR;
                    cntNext   = FIRST_IDX;
                end else if (anyXfer) begin
                    lastGrantLsuNext = lsuXfer;
                    // x0 writes are consumed but never reach the file.
                    if (selRd != '0) begin
                        weNext     = 1'b1;
                        wrRegNext  = selRd;
                        wrDataNext = selData;
                    end
                end
            end
            default: begin
                stateNext = RESET_STATE;
                cntNext   = FIRST_IDX;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg        <= RESET_STATE;
            cntReg          <= FIRST_IDX;
            lastGrantLsuReg <= 1'b1;
            busyReg         <= CLEAR_ON_RESET;
            writeEnable     <= 1'b0;
            wrReg           <= '0;
            wrData          <= '0;
        end else begin
            stateReg        <= stateNext;
            cntReg          <= cntNext;
            lastGrantLsuReg <= lastGrantLsuNext;
            // busy tracks the registered clear writes, so it lags the state by a cycle.
            busyReg         <= (stateReg == CLEAR);
            writeEnable     <= weNext;
            wrReg           <= wrRegNext;
            wrData          <= wrDataNext;
        end
    end

    assign busy = busyReg;

endmodule
